// File: rtl/rapid_pkg.sv
// Shared types and helpers for the rapid core's memory access stage.
package rapid_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [2:0] funct3;
    logic [4:0] rd;
  } control_mem_s;

  // An access faults on an unknown size code or when it is not naturally aligned.
  function automatic logic access_fault(input logic [2:0] funct3, input logic [1:0] lsb);
    case (funct3)
      F3_B, F3_BU: access_fault = 1'b0;
      F3_H, F3_HU: access_fault = lsb[0];
      F3_W:        access_fault = (lsb != 2'b00);
      default:     access_fault = 1'b1;
    endcase
  endfunction

  // Byte-lane enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] lsb);
    case (funct3)
      F3_B, F3_BU: byte_enable = 4'b0001 << lsb;
      F3_H, F3_HU: byte_enable = 4'b0011 << lsb;
      default:     byte_enable = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the enables alone pick the target bytes.
  function automatic logic [31:0] store_replicate(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_B, F3_BU: store_replicate = {4{data[7:0]}};
      F3_H, F3_HU: store_replicate = {2{data[15:0]}};
      default:     store_replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Execute-side handshake, data-memory bus and writeback signals of the MEM stage.
interface memory_access_stage_if;
  logic                   i_valid;
  logic                   o_ready;
  rapid_pkg::control_mem_s i_control_signal;
  logic [31:0]            i_rd_output;
  logic [31:0]            i_memory_data;
  logic                   o_dmem_req;
  logic                   o_dmem_we;
  logic [31:0]            o_dmem_addr;
  logic [3:0]             o_dmem_be;
  logic [31:0]            o_dmem_wdata;
  logic                   i_dmem_ack;
  logic                   i_dmem_rvalid;
  logic [31:0]            i_dmem_rdata;
  logic                   o_wb_valid;
  logic                   o_wb_we;
  logic [4:0]             o_wb_rd;
  logic [31:0]            o_wb_data;
  logic                   o_mem_fault;

  // The stage itself.
  modport slave (
    input  i_valid, i_control_signal, i_rd_output, i_memory_data,
           i_dmem_ack, i_dmem_rvalid, i_dmem_rdata,
    output o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
           o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, o_mem_fault
  );

  // Whatever drives the stage: execute, data memory and writeback together.
  modport master (
    output i_valid, i_control_signal, i_rd_output, i_memory_data,
           i_dmem_ack, i_dmem_rvalid, i_dmem_rdata,
    input  o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
           o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, o_mem_fault
  );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword lane out of a loaded word and extends it.
module mem_load_align
  import rapid_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select then extension by access size and signedness.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    byte_lane = rdata[7:0];
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    case (addr)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    case (funct3)
      F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   data = {24'd0, byte_lane};
      F3_H:    data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   data = {16'd0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: load/store FSM against a single-port data memory plus writeback.
module memory_access_stage
  import rapid_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                  i_clk,
  input logic                  i_rst,
  memory_access_stage_if.slave bus
);

  mem_state_e      state;
  control_mem_s    ctrl;
  logic [XLEN-1:0] addr;
  logic [1:0]      lsb_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            reg_write_q;
  logic [31:0]     load_data;

  assign ctrl     = bus.i_control_signal;
  assign addr     = bus.i_rd_output;
  assign bus.o_ready = (state == IDLE);

  mem_load_align u_load_align (
    .rdata  (bus.i_dmem_rdata),
    .addr   (lsb_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Stage FSM with the request and writeback registers it owns.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      lsb_q            <= '0;
      funct3_q         <= '0;
      rd_q             <= '0;
      reg_write_q      <= 1'b0;
      bus.o_dmem_req   <= 1'b0;
      bus.o_dmem_we    <= 1'b0;
      bus.o_dmem_addr  <= '0;
      bus.o_dmem_be    <= '0;
      bus.o_dmem_wdata <= '0;
      bus.o_wb_valid   <= 1'b0;
      bus.o_wb_we      <= 1'b0;
      bus.o_wb_rd      <= '0;
      bus.o_wb_data    <= '0;
      bus.o_mem_fault  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      bus.o_wb_valid  <= 1'b0;
      bus.o_mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            if (ctrl.mem_read || ctrl.mem_write) begin
              if (access_fault(ctrl.funct3, addr[1:0])) begin
                bus.o_mem_fault <= 1'b1;
              end else begin
                lsb_q            <= addr[1:0];
                funct3_q         <= ctrl.funct3;
                rd_q             <= ctrl.rd;
                reg_write_q      <= ctrl.reg_write;
                bus.o_dmem_req   <= 1'b1;
                bus.o_dmem_we    <= ctrl.mem_write;
                bus.o_dmem_addr  <= {addr[31:2], 2'b00};
                bus.o_dmem_be    <= byte_enable(ctrl.funct3, addr[1:0]);
                bus.o_dmem_wdata <= store_replicate(ctrl.funct3, bus.i_memory_data);
                state            <= REQ;
              end
            end else begin
              bus.o_wb_valid <= 1'b1;
              bus.o_wb_we    <= ctrl.reg_write && (ctrl.rd != 5'd0);
              bus.o_wb_rd    <= ctrl.rd;
              bus.o_wb_data  <= addr;
            end
          end
        end
        REQ: begin
          if (bus.i_dmem_ack) begin
            bus.o_dmem_req <= 1'b0;
            state          <= bus.o_dmem_we ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus.i_dmem_rvalid) begin
            bus.o_wb_valid <= 1'b1;
            bus.o_wb_we    <= reg_write_q && (rd_q != 5'd0);
            bus.o_wb_rd    <= rd_q;
            bus.o_wb_data  <= load_data;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
